uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
Frame parser and write sequencer placed after the UART receiver.
- Consumes the receiver's one-cycle byte-valid strobes and assembles command frames of the form SOF, ADDR, LEN, DATA[LEN], CSUM.
- Buffers the payload and checks length and XOR checksum.
- Only after the frame is verified, replays the payload as a burst of register writes over a valid/ready write port.
- Detects inter-byte timeouts so that a truncated frame cannot stall the parser.

Parameters:
MAX_LEN, 8, maximum payload bytes per frame (1..16); buffer depth.
TIMEOUT_CLKS, 20840, idle clocks allowed between bytes inside a frame (about 2 byte times at 1042 clks/bit).
SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
i_Clock  in  1  system clock.
i_Reset  in  1  reset, asynchronous, active-high.
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte valid.
i_Rx_Byte  in  8  received byte.
o_Wr_En  out  1  write request, held until accepted.
o_Wr_Addr  out  8  write address.
o_Wr_Data  out  8  write data.
i_Wr_Ready  in  1  write accepted when o_Wr_En and i_Wr_Ready are both high.
o_Busy  out  1  high in any state other than IDLE.
o_Frame_Ok  out  1  one-cycle pulse after the last write of a good frame.
o_Frame_Err  out  1  one-cycle pulse on frame rejection.
o_Err_Code  out  2  00 none, 01 timeout, 10 bad LEN, 11 checksum; held until the next SOF is accepted.
o_Drop  out  1  one-cycle pulse when a byte arrives during WRITE or DONE and is discarded.

Behaviour:
- Reset (asynchronous, while i_Reset=1): state IDLE; all outputs 0; o_Err_Code=00; counters, checksum and buffer index cleared.
- Reset asserted mid-frame or mid-burst aborts the frame with no Ok/Err pulse.
- All outputs are registered.
- IDLE:
  - i_Rx_DV with byte==SOF_BYTE -> ADDR; clear checksum and timer; o_Err_Code<=00.
  - Any other byte is ignored silently.
- ADDR: on DV latch base address, chk<=byte -> LEN.
- LEN: on DV, chk^=byte.
  - byte==0 or byte>MAX_LEN -> Err code 10 -> IDLE.
  - Otherwise latch len -> DATA.
- DATA: each DV stores byte at buf[idx], chk^=byte, idx++. The DV that brings the stored count to len moves to CSUM.
- CSUM: on DV compare byte with chk.
  - Equal -> WRITE, idx<=0.
  - Not equal -> Err code 11 -> IDLE.
- Timeout:
  - Timer counts in ADDR, LEN, DATA and CSUM, and clears on every DV.
  - Reaching TIMEOUT_CLKS-1 with no DV -> Err code 01 -> IDLE.
  - DV in the same cycle as expiry: the DV wins and the timer clears.
- Error exit: o_Frame_Err pulses in the cycle after the offending DV or expiry, with o_Err_Code valid in the same cycle.
- WRITE:
  - o_Wr_En=1 with Addr=base+idx (8-bit, wraps 0xFF->0x00) and Data=buf[idx].
  - Addr and Data stay stable while i_Wr_Ready=0.
  - On acceptance: next byte is presented the next cycle (back-to-back, one write per clock at best).
  - Acceptance of the last byte drops o_Wr_En the next cycle -> DONE.
- DONE: o_Frame_Ok=1 for one cycle -> IDLE.
- Latency: CSUM DV at cycle N -> o_Wr_En high at N+1. o_Frame_Ok rises 1 cycle after the final acceptance.
- Bytes arriving in WRITE or DONE are discarded with an o_Drop pulse; the in-progress burst is unaffected.
- SOF_BYTE appearing inside ADDR, LEN, DATA or CSUM is treated as ordinary data, with no resync.
- i_Wr_Ready outside WRITE is ignored.

Decomposition:
- Package uart_cmd_pkg: state encoding (IDLE, ADDR, LEN, DATA, CSUM, WRITE, DONE), error-code constants, SOF default.
- Sub-module uart_cmd_timeout: loadable down-counter with clear and expire outputs, parameterised by TIMEOUT_CLKS.
- Payload buffer is a local register array in the top module.

Test Plan:
1. Good frame: A5,10,02,11,22,21 with i_Wr_Ready=1 -> writes (10,11) then (11,22) on consecutive cycles; o_Frame_Ok pulse; o_Err_Code=00.
2. Bad checksum: A5,10,02,11,22,20 -> no o_Wr_En; o_Frame_Err pulse; o_Err_Code=11; o_Busy=0 next cycle.
3. Length limits:
   - A5,10,00 -> code 10.
   - A5,10,09 with MAX_LEN=8 -> code 10.
   - A5,10,08 followed by 8 data bytes and the correct CSUM -> 8 writes, addresses 10..17.
4. Timeout and backpressure:
   - Timeout: A5,10 then silence for TIMEOUT_CLKS -> code 01. A DV exactly at expiry keeps the frame alive.
   - Backpressure: frame A5,FF,02,AA,55,02 with i_Wr_Ready low 5 cycles per byte -> Addr/Data stable while stalled; writes (FF,AA),(00,55); o_Frame_Ok.
5. Drop and reset:
   - Byte strobed during WRITE -> o_Drop pulse; burst completes unchanged.
   - i_Reset asserted mid-DATA -> immediate IDLE, all outputs 0, no Ok/Err pulse.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame sequencer.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // A LEN byte is usable when it is non-zero and fits the payload buffer.
    function automatic logic len_valid(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: reloadable down-counter with a registered expiry flag.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 20840
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Flag is registered alongside the count so it reads true in the cycle the count is zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= (cnt_d == '0);
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses SOF/ADDR/LEN/DATA/CSUM frames from the UART receiver and, once the
// checksum verifies, replays the payload as a burst of valid/ready register writes.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned TIMEOUT_CLKS = 20840,
    parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    input  logic       i_Wr_Ready,
    output logic       o_Busy,
    output logic       o_Frame_Ok,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Drop
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t           state_q;
    logic [7:0]       base_q;
    logic [7:0]       chk_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;
    logic [7:0]       buf_q [MAX_LEN];
    logic             busy_q;
    logic             wr_en_q;
    logic [7:0]       wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             frame_ok_q;
    logic             frame_err_q;
    logic [1:0]       err_code_q;
    logic             drop_q;

    logic tmo_expire;
    logic in_frame_c;
    logic timeout_hit_c;

    assign in_frame_c = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                        (state_q == ST_DATA) || (state_q == ST_CSUM);
    // A byte landing on the expiry cycle keeps the frame alive.
    assign timeout_hit_c = in_frame_c && !i_Rx_DV && tmo_expire;

    uart_cmd_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk_i    (i_Clock),
        .rst_i    (i_Reset),
        .clear_i  (i_Rx_DV),
        .en_i     (in_frame_c),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            chk_q       <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            drop_q      <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= 1'b0;

            if (timeout_hit_c) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TIMEOUT;
                state_q     <= ST_IDLE;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                            chk_q      <= '0;
                            idx_q      <= '0;
                            err_code_q <= ERR_NONE;
                            busy_q     <= 1'b1;
                            state_q    <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (i_Rx_DV) begin
                            base_q  <= i_Rx_Byte;
                            chk_q   <= i_Rx_Byte;
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (i_Rx_DV) begin
                            chk_q <= chk_q ^ i_Rx_Byte;
                            if (len_valid(i_Rx_Byte, MAX_LEN)) begin
                                last_q  <= IDX_W'(i_Rx_Byte - 8'd1);
                                idx_q   <= '0;
                                state_q <= ST_DATA;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_LEN;
                                busy_q      <= 1'b0;
                                state_q     <= ST_IDLE;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (i_Rx_DV) begin
                            buf_q[idx_q] <= i_Rx_Byte;
                            chk_q        <= chk_q ^ i_Rx_Byte;
                            if (idx_q == last_q) begin
                                state_q <= ST_CSUM;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == chk_q) begin
                                idx_q     <= '0;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= base_q;
                                wr_data_q <= buf_q[0];
                                state_q   <= ST_WRITE;
                            end else begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= ERR_CSUM;
                                busy_q      <= 1'b0;
                                state_q     <= ST_IDLE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        drop_q <= i_Rx_DV;
                        if (i_Wr_Ready) begin
                            if (idx_q == last_q) begin
                                wr_en_q    <= 1'b0;
                                frame_ok_q <= 1'b1;
                                state_q    <= ST_DONE;
                            end else begin
                                idx_q     <= idx_q + IDX_W'(1);
                                wr_addr_q <= base_q + 8'(idx_q) + 8'd1;
                                wr_data_q <= buf_q[idx_q + IDX_W'(1)];
                            end
                        end
                    end
                    ST_DONE: begin
                        drop_q  <= i_Rx_DV;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        wr_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_Wr_En     = wr_en_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Wr_Data   = wr_data_q;
    assign o_Busy      = busy_q;
    assign o_Frame_Ok  = frame_ok_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Err_Code  = err_code_q;
    assign o_Drop      = drop_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scenario bench for uart_cmd_sequencer with a write scoreboard fed by the frame model.
module tb_uart_cmd_sequencer;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TMO     = 40;
    localparam logic [7:0]  SOF     = 8'hA5;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       i_Wr_Ready = 1'b1;
    logic       o_Wr_En;
    logic [7:0] o_Wr_Addr;
    logic [7:0] o_Wr_Data;
    logic       o_Busy;
    logic       o_Frame_Ok;
    logic       o_Frame_Err;
    logic [1:0] o_Err_Code;
    logic       o_Drop;

    int tests_run = 0;
    int failed    = 0;
    int ok_cnt    = 0;
    int err_cnt   = 0;
    int drop_cnt  = 0;
    int wr_cnt    = 0;

    logic [15:0] exp_q [$];
    logic        stall_seen = 1'b0;
    logic [15:0] stall_word = 16'h0;
    logic [15:0] exp_w;

    uart_cmd_sequencer #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO),
        .SOF_BYTE     (SOF)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Wr_En     (o_Wr_En),
        .o_Wr_Addr   (o_Wr_Addr),
        .o_Wr_Data   (o_Wr_Data),
        .i_Wr_Ready  (i_Wr_Ready),
        .o_Busy      (o_Busy),
        .o_Frame_Ok  (o_Frame_Ok),
        .o_Frame_Err (o_Frame_Err),
        .o_Err_Code  (o_Err_Code),
        .o_Drop      (o_Drop)
    );

    always #5 i_Clock = ~i_Clock;

    // Write-port monitor: pops the scoreboard on every accepted write, checks stalled words hold.
    always @(negedge i_Clock) begin
        if (i_Reset) begin
            stall_seen = 1'b0;
        end else begin
            if (o_Frame_Ok)  ok_cnt++;
            if (o_Frame_Err) err_cnt++;
            if (o_Drop)      drop_cnt++;
            if (stall_seen && o_Wr_En) begin
                tests_run++;
                if ({o_Wr_Addr, o_Wr_Data} !== stall_word) begin
                    failed++;
                    $display("FAIL stall_stable: addr/data %h, required %h", {o_Wr_Addr, o_Wr_Data}, stall_word);
                end
            end
            stall_seen = o_Wr_En && !i_Wr_Ready;
            stall_word = {o_Wr_Addr, o_Wr_Data};
            if (o_Wr_En && i_Wr_Ready) begin
                wr_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_write: addr %h data %h, required no write", o_Wr_Addr, o_Wr_Data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({o_Wr_Addr, o_Wr_Data} !== exp_w) begin
                        failed++;
                        $display("FAIL write_word: addr/data %h, required %h", {o_Wr_Addr, o_Wr_Data}, exp_w);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick();
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
    endtask

    // Sends a full frame; a good one queues its writes, a corrupted one flips the CSUM LSB.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] pl [$], input logic corrupt);
        logic [7:0] c;
        c = base ^ 8'(pl.size());
        send_byte(SOF);
        send_byte(base);
        send_byte(8'(pl.size()));
        for (int i = 0; i < pl.size(); i++) begin
            c = c ^ pl[i];
            if (!corrupt) exp_q.push_back({8'(base + 8'(i)), pl[i]});
            send_byte(pl[i]);
        end
        send_byte(corrupt ? (c ^ 8'h01) : c);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_Busy && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (o_Busy !== 1'b0) begin
            failed++;
            $display("FAIL %s_idle: o_Busy %b, required 0 within 200 cycles", tag, o_Busy);
        end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        #3;
        tests_run++;
        if ({o_Wr_En, o_Busy, o_Frame_Ok, o_Frame_Err, o_Drop, o_Wr_Addr, o_Wr_Data, o_Err_Code} !== 23'h0) begin
            failed++;
            $display("FAIL reset_outputs: %h, required 0",
                     {o_Wr_En, o_Busy, o_Frame_Ok, o_Frame_Err, o_Drop, o_Wr_Addr, o_Wr_Data, o_Err_Code});
        end
        tick();
        tick();
        i_Reset = 1'b0;
        tick();
        tests_run++;
        if (o_Busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_busy: %b, required 0", o_Busy);
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] pl [$];
        int ok0 = ok_cnt;
        i_Wr_Ready = 1'b1;
        pl.push_back(8'h11);
        pl.push_back(8'h22);
        send_frame(8'h10, pl, 1'b0);
        tests_run++;
        if ({o_Wr_En, o_Wr_Addr, o_Wr_Data} !== {1'b1, 8'h10, 8'h11}) begin
            failed++;
            $display("FAIL good_first_write: en/addr/data %h, required %h", {o_Wr_En, o_Wr_Addr, o_Wr_Data}, {1'b1, 8'h10, 8'h11});
        end
        tick();
        tests_run++;
        if ({o_Wr_En, o_Wr_Addr, o_Wr_Data} !== {1'b1, 8'h11, 8'h22}) begin
            failed++;
            $display("FAIL good_second_write: en/addr/data %h, required %h", {o_Wr_En, o_Wr_Addr, o_Wr_Data}, {1'b1, 8'h11, 8'h22});
        end
        tick();
        tests_run++;
        if ({o_Wr_En, o_Frame_Ok, o_Busy} !== 3'b011) begin
            failed++;
            $display("FAIL good_done: en/ok/busy %b, required 011", {o_Wr_En, o_Frame_Ok, o_Busy});
        end
        tick();
        tests_run++;
        if ({o_Busy, o_Frame_Ok, o_Err_Code} !== 4'b0000) begin
            failed++;
            $display("FAIL good_idle: busy/ok/code %b, required 0000", {o_Busy, o_Frame_Ok, o_Err_Code});
        end
        tests_run++;
        if (exp_q.size() != 0 || ok_cnt != ok0 + 1) begin
            failed++;
            $display("FAIL good_scoreboard: pending %0d ok %0d, required 0 and %0d", exp_q.size(), ok_cnt, ok0 + 1);
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] pl [$];
        int w0 = wr_cnt;
        pl.push_back(8'h11);
        pl.push_back(8'h22);
        send_frame(8'h10, pl, 1'b1);
        tests_run++;
        if ({o_Frame_Err, o_Err_Code, o_Busy, o_Wr_En} !== 5'b11100) begin
            failed++;
            $display("FAIL csum_err: err/code/busy/en %b, required 11100", {o_Frame_Err, o_Err_Code, o_Busy, o_Wr_En});
        end
        tick();
        tests_run++;
        if ({o_Frame_Err, o_Err_Code} !== 3'b011 || wr_cnt != w0) begin
            failed++;
            $display("FAIL csum_hold: err/code %b writes %0d, required 011 and %0d", {o_Frame_Err, o_Err_Code}, wr_cnt, w0);
        end
    endtask

    task automatic test_len_limits();
        logic [7:0] pl [$];
        int ok0;
        send_byte(SOF);
        send_byte(8'h10);
        send_byte(8'h00);
        tests_run++;
        if ({o_Frame_Err, o_Err_Code} !== 3'b110) begin
            failed++;
            $display("FAIL len_zero: err/code %b, required 110", {o_Frame_Err, o_Err_Code});
        end
        tick();
        send_byte(SOF);
        tests_run++;
        if (o_Err_Code !== 2'b00) begin
            failed++;
            $display("FAIL sof_clears_code: %b, required 00", o_Err_Code);
        end
        send_byte(8'h10);
        send_byte(8'h09);
        tests_run++;
        if ({o_Frame_Err, o_Err_Code} !== 3'b110) begin
            failed++;
            $display("FAIL len_over: err/code %b, required 110", {o_Frame_Err, o_Err_Code});
        end
        tick();
        ok0 = ok_cnt;
        i_Wr_Ready = 1'b1;
        for (int i = 0; i < 8; i++) pl.push_back(8'(8'h80 + 8'(i * 7)));
        send_frame(8'h10, pl, 1'b0);
        wait_idle("len_max");
        tests_run++;
        if (exp_q.size() != 0 || ok_cnt != ok0 + 1 || o_Err_Code !== 2'b00) begin
            failed++;
            $display("FAIL len_max: pending %0d ok %0d code %b, required 0, %0d, 00", exp_q.size(), ok_cnt, ok0 + 1, o_Err_Code);
        end
    endtask

    task automatic test_timeout();
        int ok0;
        int e0;
        send_byte(SOF);
        send_byte(8'h10);
        repeat (TMO - 1) tick();
        tests_run++;
        if ({o_Frame_Err, o_Busy} !== 2'b01) begin
            failed++;
            $display("FAIL timeout_early: err/busy %b, required 01", {o_Frame_Err, o_Busy});
        end
        tick();
        tests_run++;
        if ({o_Frame_Err, o_Err_Code, o_Busy} !== 4'b1010) begin
            failed++;
            $display("FAIL timeout_fire: err/code/busy %b, required 1010", {o_Frame_Err, o_Err_Code, o_Busy});
        end
        tick();
        i_Wr_Ready = 1'b1;
        ok0 = ok_cnt;
        e0  = err_cnt;
        send_byte(SOF);
        send_byte(8'h10);
        repeat (TMO - 1) tick();
        send_byte(8'h01);
        tests_run++;
        if ({o_Frame_Err, o_Busy} !== 2'b01) begin
            failed++;
            $display("FAIL timeout_dv_wins: err/busy %b, required 01", {o_Frame_Err, o_Busy});
        end
        exp_q.push_back({8'h10, 8'h33});
        send_byte(8'h33);
        send_byte(8'h10 ^ 8'h01 ^ 8'h33);
        wait_idle("timeout_alive");
        tests_run++;
        if (ok_cnt != ok0 + 1 || err_cnt != e0 || exp_q.size() != 0) begin
            failed++;
            $display("FAIL timeout_alive: ok %0d err %0d pending %0d, required %0d, %0d, 0", ok_cnt, err_cnt, exp_q.size(), ok0 + 1, e0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pl [$];
        int ok0 = ok_cnt;
        i_Wr_Ready = 1'b0;
        pl.push_back(8'hAA);
        pl.push_back(8'h55);
        send_frame(8'hFF, pl, 1'b0);
        for (int k = 0; k < 2; k++) begin
            repeat (5) tick();
            i_Wr_Ready = 1'b1;
            tick();
            i_Wr_Ready = 1'b0;
            if (k == 0) begin
                tests_run++;
                if ({o_Wr_En, o_Wr_Addr, o_Wr_Data} !== {1'b1, 8'h00, 8'h55}) begin
                    failed++;
                    $display("FAIL bp_wrap: en/addr/data %h, required %h", {o_Wr_En, o_Wr_Addr, o_Wr_Data}, {1'b1, 8'h00, 8'h55});
                end
            end
        end
        tests_run++;
        if ({o_Wr_En, o_Frame_Ok} !== 2'b01) begin
            failed++;
            $display("FAIL bp_done: en/ok %b, required 01", {o_Wr_En, o_Frame_Ok});
        end
        wait_idle("bp");
        tests_run++;
        if (exp_q.size() != 0 || ok_cnt != ok0 + 1) begin
            failed++;
            $display("FAIL bp_scoreboard: pending %0d ok %0d, required 0 and %0d", exp_q.size(), ok_cnt, ok0 + 1);
        end
        i_Wr_Ready = 1'b1;
    endtask

    task automatic test_drop();
        logic [7:0] pl [$];
        int d0 = drop_cnt;
        i_Wr_Ready = 1'b0;
        pl.push_back(8'h44);
        send_frame(8'h20, pl, 1'b0);
        tick();
        send_byte(8'h77);
        tests_run++;
        if ({o_Drop, o_Wr_En, o_Wr_Addr, o_Wr_Data} !== {2'b11, 8'h20, 8'h44}) begin
            failed++;
            $display("FAIL drop_write: drop/en/addr/data %h, required %h", {o_Drop, o_Wr_En, o_Wr_Addr, o_Wr_Data}, {2'b11, 8'h20, 8'h44});
        end
        i_Wr_Ready = 1'b1;
        tick();
        send_byte(SOF);
        tests_run++;
        if ({o_Drop, o_Busy} !== 2'b10) begin
            failed++;
            $display("FAIL drop_done: drop/busy %b, required 10", {o_Drop, o_Busy});
        end
        tick();
        tests_run++;
        if (o_Busy !== 1'b0 || exp_q.size() != 0 || drop_cnt != d0 + 2) begin
            failed++;
            $display("FAIL drop_after: busy %b pending %0d drops %0d, required 0, 0, %0d", o_Busy, exp_q.size(), drop_cnt, d0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl [$];
        int ok0 = ok_cnt;
        int e0  = err_cnt;
        send_byte(SOF);
        send_byte(8'h10);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        i_Reset = 1'b1;
        #1;
        tests_run++;
        if ({o_Wr_En, o_Busy, o_Frame_Ok, o_Frame_Err, o_Drop, o_Wr_Addr, o_Wr_Data, o_Err_Code} !== 23'h0) begin
            failed++;
            $display("FAIL reset_mid_outputs: %h, required 0",
                     {o_Wr_En, o_Busy, o_Frame_Ok, o_Frame_Err, o_Drop, o_Wr_Addr, o_Wr_Data, o_Err_Code});
        end
        tick();
        tick();
        i_Reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (ok_cnt != ok0 || err_cnt != e0 || o_Busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_pulses: ok %0d err %0d busy %b, required %0d, %0d, 0", ok_cnt, err_cnt, o_Busy, ok0, e0);
        end
        i_Wr_Ready = 1'b1;
        pl.push_back(8'h5A);
        send_frame(8'h30, pl, 1'b0);
        wait_idle("reset_recover");
        tests_run++;
        if (exp_q.size() != 0 || ok_cnt != ok0 + 1) begin
            failed++;
            $display("FAIL reset_recover: pending %0d ok %0d, required 0 and %0d", exp_q.size(), ok_cnt, ok0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_limits();
        test_timeout();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
